dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bundle between the LSU and dmem_ctrl
interface dmem_ctrl_if #(
    parameter int ADDR_W = 9
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte/half/word data memory with valid/ready requests and read latency
// Optional: DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors instead of force-aligning.
module dmem_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 128,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_ctrl_if.slave  bus
);
    localparam int          IDX_W    = ADDR_W - 2;
    localparam int          MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] hold_q;
    logic [1:0]  lane_q, size_q;
    logic        uns_q, err_q, we_q;

    logic              accept, bad, err_req;
    logic [ADDR_W-1:0] addr_eff;
    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] mem_idx;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       shifted, load_val;

    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        addr_eff = bus.req_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        bad = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        bad = 1'b0;
        if (bus.req_size == 2'b01)
            addr_eff[0] = 1'b0;
        else if (bus.req_size == 2'b10)
            addr_eff[1:0] = 2'b00;
`endif
        idx     = addr_eff[ADDR_W-1:2];
        mem_idx = idx[MEM_AW-1:0];
        err_req = (bus.req_size == 2'b11) || (32'(idx) >= DEPTH) || bad;

        be    = 4'b0000;
        wword = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be    = 4'b0001 << addr_eff[1:0];
                wword = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be    = addr_eff[1] ? 4'b1100 : 4'b0011;
                wword = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array and read-holding register carry no reset; a store lands at its acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && !err_req) begin
            if (bus.req_we) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[mem_idx][8*i +: 8] <= wword[8*i +: 8];
            end else begin
                hold_q <= mem[mem_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lane_q <= addr_eff[1:0];
                size_q <= bus.req_size;
                uns_q  <= bus.req_unsigned;
                err_q  <= err_req;
                we_q   <= bus.req_we;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!bus.req_we && !err_req && (READ_LAT > 1)) begin
                        state_d = BUSY;
                        cnt_d   = 2'd1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shifted  = hold_q >> {lane_q, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl at READ_LAT 1 and 3
module tb_dmem_ctrl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] mdl [128];

    dmem_ctrl_if #(.ADDR_W(10)) bus1 ();
    dmem_ctrl_if #(.ADDR_W(10)) bus3 ();

    dmem_ctrl #(.ADDR_W(10), .DEPTH(128), .READ_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_ctrl #(.ADDR_W(10), .DEPTH(128), .READ_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory rules applied directly to the word array.
    task automatic model_access(input logic we, input logic [1:0] size, input logic uns,
                                input logic [9:0] addr, input logic [31:0] wd,
                                output logic e_err, output logic [31:0] e_rd, output logic e_ld);
        int idx, lane, nb;
        logic mis;
        logic [63:0] v, mask;
        idx  = int'(addr) / 4;
        lane = int'(addr) % 4;
        nb   = (size == 2'b11) ? 0 : (1 << size);
        mis  = (nb > 1) && ((lane % nb) != 0);
        e_err = (size == 2'b11) || (idx >= 128);
`ifdef DMEM_MISALIGN_TRAP_EN
        e_err = e_err || mis;
`else
        if (mis) lane = lane - (lane % nb);
`endif
        e_rd = 32'd0;
        e_ld = 1'b0;
        if (!e_err) begin
            if (we) begin
                for (int b = 0; b < nb; b++) mdl[idx][8*(lane+b) +: 8] = wd[8*b +: 8];
            end else begin
                e_ld = 1'b1;
                v    = 64'(mdl[idx] >> (8*lane));
                mask = (64'd1 << (8*nb)) - 64'd1;
                v    = v & mask;
                if (!uns && v[8*nb-1]) v = v | ~mask;
                e_rd = v[31:0];
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wd,
                          output logic o_err, output logic [31:0] o_rd);
        logic e_err, e_ld;
        logic [31:0] e_rd;
        int lat1, lat3;
        model_access(we, size, uns, addr, wd, e_err, e_rd, e_ld);
        lat1 = 0; lat3 = 0; o_err = 1'b0; o_rd = 32'd0;
        @(negedge clk);
        chk("ready1_pre", 32'(bus1.req_ready), 32'd1);
        chk("ready3_pre", 32'(bus3.req_ready), 32'd1);
        bus1.req_we = we; bus1.req_size = size; bus1.req_unsigned = uns;
        bus1.req_addr = addr; bus1.req_wdata = wd; bus1.req_valid = 1'b1;
        bus3.req_we = we; bus3.req_size = size; bus3.req_unsigned = uns;
        bus3.req_addr = addr; bus3.req_wdata = wd; bus3.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        bus3.req_valid = 1'b0;
        for (int k = 1; k <= 8 && (lat1 == 0 || lat3 == 0); k++) begin
            @(negedge clk);
            if (lat1 == 0 && bus1.rsp_valid) begin
                lat1  = k;
                o_err = bus1.rsp_err;
                o_rd  = bus1.rsp_rdata;
                chk("err1", 32'(bus1.rsp_err), 32'(e_err));
                chk("rdata1", bus1.rsp_rdata, e_rd);
            end
            if (lat3 == 0) begin
                if (bus3.rsp_valid) begin
                    lat3 = k;
                    chk("err3", 32'(bus3.rsp_err), 32'(e_err));
                    chk("rdata3", bus3.rsp_rdata, e_rd);
                end else begin
                    chk("busy_ready3", 32'(bus3.req_ready), 32'd0);
                end
            end
        end
        chk("lat1", 32'(lat1), 32'd1);
        chk("lat3", 32'(lat3), e_ld ? 32'd3 : 32'd1);
        @(negedge clk);
        chk("idle_valid", {30'd0, bus1.rsp_valid, bus3.rsp_valid}, 32'd0);
        chk("idle_rdata", bus1.rsp_rdata | bus3.rsp_rdata, 32'd0);
        chk("idle_ready", {30'd0, bus1.req_ready, bus3.req_ready}, 32'd3);
    endtask

    initial begin
        logic        oe, e_err, e_ld;
        logic [31:0] od, exp_a, exp_b, ra, rb;
        logic [6:0]  rv, vv;
        int          stray;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b00;
        bus1.req_unsigned = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_size = 2'b00;
        bus3.req_unsigned = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {30'd0, bus1.req_ready, bus3.req_ready}, 32'd3);
        chk("rst_valid", {30'd0, bus1.rsp_valid, bus3.rsp_valid}, 32'd0);
        chk("rst_err", {30'd0, bus1.rsp_err, bus3.rsp_err}, 32'd0);
        chk("rst_rdata", bus1.rsp_rdata | bus3.rsp_rdata, 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < 128; w++) do_req(1'b1, 2'b10, 1'b0, 10'(w*4), $urandom, oe, od);

        do_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, oe, od);
        chk("sw_err", 32'(oe), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, oe, od);
        chk("lw_deadbeef", od, 32'hDEADBEEF);

        do_req(1'b1, 2'b00, 1'b0, 10'h011, 32'h000000AA, oe, od);
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, oe, od);
        chk("sb_merge", od, 32'hDEADAAEF);
        do_req(1'b0, 2'b00, 1'b0, 10'h011, 32'd0, oe, od);
        chk("lb_sext", od, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 10'h011, 32'd0, oe, od);
        chk("lbu_zext", od, 32'h000000AA);

        do_req(1'b0, 2'b10, 1'b0, 10'h020, 32'd0, oe, exp_a);
        do_req(1'b1, 2'b01, 1'b0, 10'h022, 32'h00008001, oe, od);
        do_req(1'b0, 2'b01, 1'b0, 10'h022, 32'd0, oe, od);
        chk("lh_sext", od, 32'hFFFF8001);
        do_req(1'b0, 2'b01, 1'b1, 10'h022, 32'd0, oe, od);
        chk("lhu_zext", od, 32'h00008001);
        do_req(1'b0, 2'b10, 1'b0, 10'h020, 32'd0, oe, od);
        chk("sh_upper", {16'd0, od[31:16]}, 32'h00008001);
        chk("sh_lower", {16'd0, od[15:0]}, {16'd0, exp_a[15:0]});

        do_req(1'b0, 2'b10, 1'b0, 10'h200, 32'd0, oe, od);
        chk("oor_err", 32'(oe), 32'd1);
        chk("oor_rdata", od, 32'd0);
        do_req(1'b1, 2'b11, 1'b0, 10'h010, 32'h12345678, oe, od);
        chk("rsvd_err", 32'(oe), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, oe, od);
        chk("rsvd_nowrite", od, 32'hDEADAAEF);

        do_req(1'b0, 2'b10, 1'b0, 10'h012, 32'd0, oe, od);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_err", 32'(oe), 32'd1);
        chk("mis_rdata", od, 32'd0);
`else
        chk("mis_err", 32'(oe), 32'd0);
        chk("mis_aligned", od, 32'hDEADAAEF);
`endif

        // Second load held on req_valid while the first is in flight.
        model_access(1'b0, 2'b10, 1'b0, 10'h010, 32'd0, e_err, exp_a, e_ld);
        model_access(1'b0, 2'b10, 1'b0, 10'h020, 32'd0, e_err, exp_b, e_ld);
        ra = 32'd0; rb = 32'd0; rv = 7'd0; vv = 7'd0;
        @(negedge clk);
        bus3.req_we = 1'b0; bus3.req_size = 2'b10; bus3.req_unsigned = 1'b0;
        bus3.req_addr = 10'h010; bus3.req_valid = 1'b1;
        @(posedge clk);
        #1 bus3.req_addr = 10'h020;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            rv[k-1] = bus3.req_ready;
            vv[k-1] = bus3.rsp_valid;
            if (k == 3) ra = bus3.rsp_rdata;
            if (k == 7) rb = bus3.rsp_rdata;
            if (k == 4) begin
                @(posedge clk);
                #1 bus3.req_valid = 1'b0;
            end
        end
        chk("hold_ready_seq", 32'(rv), 32'b0001000);
        chk("hold_valid_seq", 32'(vv), 32'b1000100);
        chk("hold_rdata_a", ra, exp_a);
        chk("hold_rdata_b", rb, exp_b);
        @(negedge clk);
        chk("hold_idle", 32'(bus3.req_ready), 32'd1);

        // Reset while the READ_LAT=3 instance is busy drops the response.
        @(negedge clk);
        bus3.req_addr = 10'h010; bus3.req_valid = 1'b1;
        @(posedge clk);
        #1 bus3.req_valid = 1'b0;
        @(negedge clk);
        chk("rstbusy_pre", 32'(bus3.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstbusy_async_ready", 32'(bus3.req_ready), 32'd1);
        chk("rstbusy_async_valid", 32'(bus3.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus3.rsp_valid || !bus3.req_ready) stray++;
        end
        chk("rstbusy_no_rsp", 32'(stray), 32'd0);

        for (int i = 0; i < 80; i++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   10'($urandom_range(0, 'h21F)), $urandom, oe, od);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
